// File: rtl/string_hw_pkg.sv
// Shared types, character constants and case helpers for the string_hw engine.
package string_hw_pkg;

   typedef enum logic [2:0] {
      OP_CMP    = 3'd0,
      OP_UPPER  = 3'd1,
      OP_LOWER  = 3'd2,
      OP_TOGGLE = 3'd3,
      OP_STRLEN = 3'd4,
      OP_COUNT  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0] CH_NUL   = 8'h00;
   localparam logic [7:0] CH_A_UP  = 8'h41;
   localparam logic [7:0] CH_Z_UP  = 8'h5A;
   localparam logic [7:0] CH_A_LO  = 8'h61;
   localparam logic [7:0] CH_Z_LO  = 8'h7A;
   localparam logic [7:0] CASE_BIT = 8'h20;

   function automatic logic is_upper(input logic [7:0] c);
      return (c >= CH_A_UP) && (c <= CH_Z_UP);
   endfunction

   function automatic logic is_lower(input logic [7:0] c);
      return (c >= CH_A_LO) && (c <= CH_Z_LO);
   endfunction

endpackage

// File: rtl/string_hw_lane.sv
// One byte lane: case transform of a plus equality, search-match and NUL flags.
module string_hw_lane
   import string_hw_pkg::*;
(
   input  op_e        op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] sch,
   output logic [7:0] y,
   output logic       eq,
   output logic       match,
   output logic       nul
);

   always_comb begin
      y = a;
      case (op)
         OP_UPPER:  if (is_lower(a)) y = a - CASE_BIT;
         OP_LOWER:  if (is_upper(a)) y = a + CASE_BIT;
         OP_TOGGLE: if (is_upper(a) || is_lower(a)) y = a ^ CASE_BIT;
         default:   y = a;
      endcase
   end

   assign eq    = (a == b);
   // A NUL search character never matches, so count-char on NUL yields zero.
   assign match = (sch != CH_NUL) && (a == sch);
   assign nul   = (a == CH_NUL);

endmodule

// File: rtl/string_hw_engine.sv
// Multi-mode string accelerator: go/done handshake, LANES bytes per RUN cycle.
// Optional macro STRING_HW_EARLY_EXIT_EN lets compare stop at the first mismatching chunk.
module string_hw_engine
   import string_hw_pkg::*;
#(
   parameter  int MAX_BLOCKS = 2,
   parameter  int LANES      = 1,
   localparam int N          = MAX_BLOCKS * 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [3:0]        index,
   input  logic [0:N-1][7:0] A,
   input  logic [0:N-1][7:0] B,
   output logic              done,
   output logic              busy,
   output logic              error,
   output logic [0:N-1][7:0] Result
);

   localparam int K   = N / LANES;
   localparam int CW  = (K > 1) ? $clog2(K) : 1;
   localparam int BW  = $clog2(N);
   localparam int LSH = $clog2(LANES);
   localparam int IW  = $clog2(N + 1);

   state_e            state, state_nx;
   logic [CW-1:0]     cnt;
   op_e               op_q;
   logic [0:N-1][7:0] a_q, b_q, res_q;
   logic              done_q, err_q;
   logic              eq_acc, seen_acc;
   logic [IW-1:0]     lead_acc, hits_acc;

   logic [BW-1:0]          base;
   logic [LANES-1:0][7:0]  ly;
   logic [LANES-1:0]       leq, lmatch, lnul;
   logic                   supported, last, chunk_eq, eq_fin, seen_c;
   logic [IW-1:0]          lead_c, hits_c;

   assign supported = (index <= 4'd5);
   assign last      = (cnt == CW'(K - 1));
   assign base      = BW'(cnt) << LSH;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [BW-1:0] pos;
      assign pos = base + BW'(l);
      string_hw_lane u_lane (
         .op    (op_q),
         .a     (a_q[pos]),
         .b     (b_q[pos]),
         .sch   (b_q[N-1]),
         .y     (ly[l]),
         .eq    (leq[l]),
         .match (lmatch[l]),
         .nul   (lnul[l])
      );
   end

   assign chunk_eq = &leq;
   assign eq_fin   = eq_acc & chunk_eq;

   // Leading-NUL run and match count carried across chunks, byte 0 first.
   always_comb begin
      seen_c = seen_acc;
      lead_c = lead_acc;
      hits_c = hits_acc;
      for (int l = 0; l < LANES; l++) begin
         if (!seen_c && lnul[l]) lead_c = lead_c + IW'(1);
         else                    seen_c = 1'b1;
         if (lmatch[l])          hits_c = hits_c + IW'(1);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (go) state_nx = supported ? RUN : DONE;
`ifdef STRING_HW_EARLY_EXIT_EN
         RUN:  if (last || (op_q == OP_CMP && !chunk_eq)) state_nx = DONE;
`else
         RUN:  if (last) state_nx = DONE;
`endif
         DONE: if (done_q && !go) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operands are captured only on accept and need no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && go) begin
         a_q  <= A;
         b_q  <= B;
         op_q <= op_e'(index[2:0]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         res_q    <= '0;
         eq_acc   <= 1'b1;
         seen_acc <= 1'b0;
         lead_acc <= '0;
         hits_acc <= '0;
      end else begin
         state  <= state_nx;
         // done rises one edge after entering DONE and drops on the edge that sees go low.
         done_q <= (state == DONE) && !(done_q && !go);
         case (state)
            IDLE: begin
               if (go) begin
                  cnt      <= '0;
                  err_q    <= !supported;
                  res_q    <= '0;
                  eq_acc   <= 1'b1;
                  seen_acc <= 1'b0;
                  lead_acc <= '0;
                  hits_acc <= '0;
               end
            end
            RUN: begin
               cnt      <= cnt + CW'(1);
               eq_acc   <= eq_fin;
               seen_acc <= seen_c;
               lead_acc <= lead_c;
               hits_acc <= hits_c;
               if (op_q == OP_UPPER || op_q == OP_LOWER || op_q == OP_TOGGLE) begin
                  for (int l = 0; l < LANES; l++) res_q[base + BW'(l)] <= ly[l];
               end
               if (state_nx == DONE) begin
                  case (op_q)
                     OP_CMP:    res_q <= {{(N*8-1){1'b0}}, eq_fin};
                     OP_STRLEN: res_q <= {{(N*8-IW){1'b0}}, IW'(N) - lead_c};
                     OP_COUNT:  res_q <= {{(N*8-IW){1'b0}}, hits_c};
                     default:   ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign done   = done_q;
   assign busy   = (state == RUN);
   assign error  = err_q;
   assign Result = res_q;

endmodule

// File: tb/tb_string_hw_engine.sv
// Self-checking bench: directed plan plus random ops, LANES=1 and LANES=4 instances side by side.
module tb_string_hw_engine;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            go = 1'b0;
   logic [3:0]      index = 4'd0;
   logic [0:7][7:0] A = '0;
   logic [0:7][7:0] B = '0;
   logic            done, busy, error, done4, busy4, error4;
   logic [0:7][7:0] res, res4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   string_hw_engine #(.MAX_BLOCKS(2), .LANES(1)) dut (
      .clk(clk), .reset(rst_n), .go(go), .index(index), .A(A), .B(B),
      .done(done), .busy(busy), .error(error), .Result(res)
   );

   string_hw_engine #(.MAX_BLOCKS(2), .LANES(4)) dut4 (
      .clk(clk), .reset(rst_n), .go(go), .index(index), .A(A), .B(B),
      .done(done4), .busy(busy4), .error(error4), .Result(res4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [0:7][7:0] rj(input string s);
      logic [0:7][7:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) r[8 - s.len() + i] = s[i];
      return r;
   endfunction

   function automatic logic [63:0] model(input logic [3:0] idx, input logic [0:7][7:0] a,
                                         input logic [0:7][7:0] b);
      logic [0:7][7:0] r;
      int n;
      r = '0;
      n = 0;
      case (idx)
         4'd0: r[7] = (a == b) ? 8'd1 : 8'd0;
         4'd1, 4'd2, 4'd3: begin
            for (int i = 0; i < 8; i++) begin
               logic up, lo;
               up = (a[i] >= 8'h41 && a[i] <= 8'h5A);
               lo = (a[i] >= 8'h61 && a[i] <= 8'h7A);
               r[i] = a[i];
               if ((idx == 4'd1 || idx == 4'd3) && lo) r[i] = a[i] - 8'd32;
               if ((idx == 4'd2 || idx == 4'd3) && up) r[i] = a[i] + 8'd32;
            end
         end
         4'd4: begin
            while (n < 8 && a[n] == 8'h00) n++;
            r[7] = 8'(8 - n);
         end
         4'd5: begin
            if (b[7] != 8'h00)
               for (int i = 0; i < 8; i++) if (a[i] == b[7]) n++;
            r[7] = 8'(n);
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic int lat_model(input logic [3:0] idx, input logic [0:7][7:0] a,
                                    input logic [0:7][7:0] b, input int lanes);
      if (idx > 4'd5) return 1;
`ifdef STRING_HW_EARLY_EXIT_EN
      if (idx == 4'd0)
         for (int i = 0; i < 8; i++) if (a[i] != b[i]) return i / lanes + 2;
`endif
      return 8 / lanes + 1;
   endfunction

   task automatic run_op(input logic [3:0] idx, input logic [0:7][7:0] a,
                         input logic [0:7][7:0] b, input int hold);
      logic [63:0] exp_r;
      int exp_l1, exp_l4, lat1, lat4, busy1, busyq, cyc, bad;
      exp_r  = model(idx, a, b);
      exp_l1 = lat_model(idx, a, b, 1);
      exp_l4 = lat_model(idx, a, b, 4);
      @(negedge clk);
      index = idx; A = a; B = b; go = 1'b1;
      @(posedge clk); #1;
      lat1 = -1; lat4 = -1; busy1 = 0; busyq = 0; cyc = 0;
      while ((lat1 < 0 || lat4 < 0) && cyc < 40) begin
         if (lat1 < 0 && busy)  busy1++;
         if (lat4 < 0 && busy4) busyq++;
         @(posedge clk); #1;
         cyc++;
         if (lat1 < 0 && done)  lat1 = cyc;
         if (lat4 < 0 && done4) lat4 = cyc;
      end
      check($sformatf("lat_l1_op%0d", idx), 64'(lat1), 64'(exp_l1));
      check($sformatf("lat_l4_op%0d", idx), 64'(lat4), 64'(exp_l4));
      check($sformatf("busy_l1_op%0d", idx), 64'(busy1), 64'(exp_l1 - 1));
      check($sformatf("busy_l4_op%0d", idx), 64'(busyq), 64'(exp_l4 - 1));
      check($sformatf("res_l1_op%0d", idx), res, exp_r);
      check($sformatf("res_l4_op%0d", idx), res4, exp_r);
      check($sformatf("err_l1_op%0d", idx), 64'(error), 64'(idx > 4'd5));
      check($sformatf("err_l4_op%0d", idx), 64'(error4), 64'(idx > 4'd5));
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (!done || busy || !done4 || busy4 || res !== exp_r) bad++;
      end
      if (hold > 0) check("hold_no_restart", 64'(bad), 64'd0);
      go = 1'b0;
      @(posedge clk); #1;
      check("done_fall_l1", 64'(done), 64'd0);
      check("done_fall_l4", 64'(done4), 64'd0);
      check("res_held", res, exp_r);
   endtask

   function automatic logic [7:0] rbyte();
      case ($urandom_range(0, 4))
         0: return 8'h41 + 8'($urandom_range(0, 25));
         1: return 8'h61 + 8'($urandom_range(0, 25));
         2: return 8'h30 + 8'($urandom_range(0, 9));
         3: return 8'($urandom_range(1, 255));
         default: return ($urandom_range(0, 1) == 0) ? 8'h61 : 8'h00;
      endcase
   endfunction

   initial begin
      logic [0:7][7:0] ra, rb;
      logic [3:0] ridx;
      int pad, j;

      #12;
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_result", res, 64'd0);
      check("rst_result_l4", res4, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(4'd0, rj("abcdefgh"), rj("abcadead"), 0);
      run_op(4'd0, rj("ab"), rj("ab"), 0);
      run_op(4'd1, rj("AbCdef"), '0, 0);
      run_op(4'd2, rj("ABCDEFGH"), '0, 0);
      run_op(4'd3, rj("AbCd1!"), '0, 0);
      run_op(4'd4, rj("ab"), '0, 0);
      run_op(4'd5, rj("banana"), rj("a"), 0);
      run_op(4'd5, rj("banana"), '0, 0);
      run_op(4'd9, rj("abc"), rj("abc"), 20);

      // Reset asserted in the middle of a run.
      @(negedge clk);
      index = 4'd1; A = rj("abcdefgh"); B = '0; go = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_error", 64'(error), 64'd0);
      check("midrst_result", res, 64'd0);
      check("midrst_busy_l4", 64'(busy4), 64'd0);
      go = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'd2, rj("AB"), '0, 0);

      for (int t = 0; t < 30; t++) begin
         ridx = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
         pad = $urandom_range(0, 8);
         for (int i = 0; i < 8; i++) ra[i] = (i < pad) ? 8'h00 : rbyte();
         case ($urandom_range(0, 2))
            0: rb = ra;
            1: begin
               rb = ra;
               j = $urandom_range(0, 7);
               rb[j] = ra[j] ^ 8'h01;
            end
            default: for (int i = 0; i < 8; i++) rb[i] = rbyte();
         endcase
         run_op(ridx, ra, rb, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/string_hw_engine.md
Name: string_hw_engine

Overview:
Parametrised multi-mode string accelerator. Next generation of the String_HW go/done block, sitting behind the NIOS2 custom-peripheral interface on the DE2-115.
- String width is a parameter.
- Processes LANES bytes per cycle through a sequential datapath.
- Adds toggle-case, string-length and character-count modes, plus an error flag for unsupported operations.

Parameters:
MAX_BLOCKS, 2, string size in 32-bit blocks; N = MAX_BLOCKS*4 bytes.
LANES, 1, bytes processed per RUN cycle. Must be a power of two that divides N. K = N/LANES RUN cycles.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
go  in  1  start request, level; sampled in IDLE.
index  in  4  operation select: 0 compare, 1 to-upper, 2 to-lower, 3 toggle-case, 4 strlen, 5 count-char; 6..15 unsupported.
A  in  [0:N-1][7:0]  operand string; byte 0 is leftmost.
B  in  [0:N-1][7:0]  second string (compare), or search char in B[N-1] (count-char).
done  out  1  result valid; held until go deasserted.
busy  out  1  high in RUN.
error  out  1  unsupported index; valid with done.
Result  out  [0:N-1][7:0]  transformed string or zero-extended integer.

Behaviour:
- Strings are right-justified. Leading 0x00 bytes are padding; every NUL byte passes through unchanged.
- Reset (reset=0, async): state=IDLE; done=0, busy=0, error=0, Result=0. Applies at any time, including mid-RUN; any in-flight operation is discarded.
- IDLE:
  - go=1 latches A, B and index.
  - Supported index -> RUN (busy=1); unsupported index -> DONE with error=1.
- RUN:
  - One chunk of LANES bytes per cycle, byte 0 first, chunk counter 0..K-1.
  - Transform ops write their chunk into the Result register.
  - After chunk K-1 -> DONE.
  - go is ignored during RUN.
- DONE:
  - done=1; Result and error stable.
  - go=1 remains in DONE, with no re-trigger.
  - go=0 -> IDLE. done falls on the next edge; Result is held until the next accept.
- Latency: done rises K+1 cycles after the accepting edge (N=8, LANES=1: 9 cycles). Unsupported index: 1 cycle.
- Op 0 compare: Result = 1 if all N bytes are equal, else 0.
- Op 1 to-upper: 'a'..'z' -> minus 0x20; all other bytes unchanged.
- Op 2 to-lower: 'A'..'Z' -> plus 0x20; all other bytes unchanged.
- Op 3 toggle-case: letters swap case; non-letters unchanged.
- Op 4 strlen: Result = N minus the count of leading NUL bytes. Integer, zero-extended, LSB in byte N-1.
- Op 5 count-char: Result = number of bytes of A equal to B[N-1]. A NUL search char yields 0.
- Integer results are at most N, so width never overflows.

Optional Feature:
STRING_HW_EARLY_EXIT_EN.
- Defined: compare leaves RUN at the end of the first chunk containing a mismatch, with Result=0. Latency = mismatching chunk index + 2 cycles.
- Undefined: compare always runs all K chunks; latency is fixed.
- All other ops are unaffected in both builds.

Decomposition:
Package string_hw_pkg holds:
- op_e enum (OP_CMP=0, OP_UPPER, OP_LOWER, OP_TOGGLE, OP_STRLEN, OP_COUNT).
- state_e (IDLE, RUN, DONE).
- Constants CH_NUL=8'h00, CH_A_UP, CH_Z_UP, CH_A_LO, CH_Z_LO, CASE_BIT=8'h20.
- Functions is_upper, is_lower.

Sub-module string_hw_lane: combinational per-byte transform plus equality/match flag, instantiated LANES times.
Top level holds the FSM, chunk counter, accumulators and Result register.

Test Plan:
- Compare (N=8, LANES=1): A="abcdefgh", B="abcadead" -> Result=0, error=0. done at cycle 9 without the feature, cycle 5 with it. A=B="ab" -> Result=1.
- To-upper: A="AbCdef" (2 pad NULs) -> Result=00 00 "ABCDEF". To-lower: A="ABCDEFGH" -> "abcdefgh". Check done exactly 9 cycles after go, and busy high for 8 cycles.
- Toggle-case: A="AbCd1!" -> "aBcD1!". With LANES=4 -> same result, done after 3 cycles.
- Strlen: A="ab" -> Result=2. Count-char: A="banana", B="a" -> Result=3. A="banana", B=0 -> Result=0.
- index=9, go=1 -> done=1 and error=1 one cycle later, Result=0. Then go held high 20 cycles -> done stays 1, busy stays 0, no restart.
- Assert reset=0 at RUN cycle 4 -> all outputs 0 immediately. Release, then go with to-lower "AB" -> Result="ab", correct latency.
